// File: rtl/led_pattern_counter.sv
// LED pattern counter: prescaled or manually stepped up/down/shift/rotate
// counter with pattern loads, terminal-count pulse and Gray-coded mirror.
module led_pattern_counter #(
  parameter int               WIDTH = 10,
  parameter int               DIV_W = 23,
  parameter logic [WIDTH-1:0] PAT_A = 10'h2AA,
  parameter logic [WIDTH-1:0] PAT_B = 10'h155
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_CLR,
  input  logic             LOAD_A,
  input  logic             LOAD_B,
  input  logic [1:0]       MODE,
  input  logic             SAT,
  input  logic             STEP_SEL,
  input  logic             STEP,
  output logic [WIDTH-1:0] CNT,
  output logic [WIDTH-1:0] GRAY,
  output logic             TC,
  output logic [1:0]       ACT
);

  typedef enum logic [1:0] {
    M_UP  = 2'b00,
    M_DN  = 2'b01,
    M_SHL = 2'b10,
    M_ROL = 2'b11
  } mode_e;

  logic [DIV_W-1:0] presc;
  logic             step_prev;
  logic             tick, step_rise, adv;
  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;

  assign tick      = &presc;
  assign step_rise = STEP & ~step_prev;
  assign adv       = STEP_SEL ? step_rise : tick;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc     <= '0;
      step_prev <= 1'b0;
      ACT       <= '0;
    end else begin
      presc     <= presc + 1'b1;
      step_prev <= STEP;
      if (tick) ACT <= ACT + 1'b1;
    end
  end

  // Clear and loads outrank the advance; any of them kills TC for that edge.
  always_comb begin
    cnt_nxt = CNT;
    tc_nxt  = 1'b0;
    if (CMD_CLR)     cnt_nxt = '0;
    else if (LOAD_A) cnt_nxt = PAT_A;
    else if (LOAD_B) cnt_nxt = PAT_B;
    else if (adv) begin
      unique case (mode_e'(MODE))
        M_UP: begin
          if (&CNT) begin
            tc_nxt  = 1'b1;
            cnt_nxt = SAT ? CNT : '0;
          end else begin
            cnt_nxt = CNT + 1'b1;
          end
        end
        M_DN: begin
          if (CNT == '0) begin
            tc_nxt  = 1'b1;
            cnt_nxt = SAT ? CNT : '1;
          end else begin
            cnt_nxt = CNT - 1'b1;
          end
        end
        M_SHL: begin
          tc_nxt  = CNT[WIDTH-1];
          cnt_nxt = {CNT[WIDTH-2:0], 1'b0};
        end
        M_ROL: begin
          tc_nxt  = CNT[WIDTH-1];
          cnt_nxt = {CNT[WIDTH-2:0], CNT[WIDTH-1]};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CNT <= '0;
      TC  <= 1'b0;
    end else begin
      CNT <= cnt_nxt;
      TC  <= tc_nxt;
    end
  end

  assign GRAY = CNT ^ (CNT >> 1);

endmodule

// File: tb/tb_led_pattern_counter.sv
// Directed bench for led_pattern_counter with a 16-cycle prescaler.
module tb_led_pattern_counter;
  localparam int WIDTH = 10;
  localparam int DIV_W = 4;
  localparam int PER   = 16;

  logic CLK = 1'b0, RST_N = 1'b0;
  logic CMD_CLR = 1'b0, LOAD_A = 1'b0, LOAD_B = 1'b0, SAT = 1'b0;
  logic STEP_SEL = 1'b0, STEP = 1'b0;
  logic [1:0] MODE = 2'b00;
  logic [WIDTH-1:0] CNT, GRAY;
  logic TC;
  logic [1:0] ACT;

  int vecs = 0, errs = 0;
  int cyc = 0;

  led_pattern_counter #(.WIDTH(WIDTH), .DIV_W(DIV_W), .PAT_A(10'h2AA), .PAT_B(10'h155)) dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_CLR(CMD_CLR), .LOAD_A(LOAD_A), .LOAD_B(LOAD_B),
    .MODE(MODE), .SAT(SAT), .STEP_SEL(STEP_SEL), .STEP(STEP),
    .CNT(CNT), .GRAY(GRAY), .TC(TC), .ACT(ACT)
  );

  always #5 CLK = ~CLK;

  // Clock edges since reset release; the tick edge is every PER-th one.
  always @(posedge CLK or negedge RST_N)
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;

  // Advance to the negedge just after the next tick edge and check ACT there.
  task automatic next_tick();
    int n = 0;
    do begin @(negedge CLK); n++; end while ((cyc % PER) != 0 && n < 40);
    vecs++;
    if (n >= 40) begin errs++; $display("FAIL tick_wait timeout after %0d cycles", n); end
    vecs++;
    if (ACT !== 2'(cyc / PER)) begin errs++; $display("FAIL act got %0d exp %0d", ACT, 2'(cyc / PER)); end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #12;
    vecs++; if (CNT !== '0)  begin errs++; $display("FAIL rst_cnt got %h exp 000", CNT); end
    vecs++; if (GRAY !== '0) begin errs++; $display("FAIL rst_gray got %h exp 000", GRAY); end
    vecs++; if (TC !== 1'b0) begin errs++; $display("FAIL rst_tc got %b exp 0", TC); end
    vecs++; if (ACT !== 2'd0) begin errs++; $display("FAIL rst_act got %0d exp 0", ACT); end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_up_ticks();
    repeat (5) next_tick();
    vecs++; if (CNT !== 10'h005)  begin errs++; $display("FAIL up_cnt got %h exp 005", CNT); end
    vecs++; if (GRAY !== 10'h007) begin errs++; $display("FAIL up_gray got %h exp 007", GRAY); end
    vecs++; if (ACT !== 2'd1)     begin errs++; $display("FAIL up_act got %0d exp 1", ACT); end
    vecs++; if (TC !== 1'b0)      begin errs++; $display("FAIL up_tc got %b exp 0", TC); end
  endtask

  task automatic test_shift();
    LOAD_A = 1'b1; @(negedge CLK); LOAD_A = 1'b0;
    vecs++; if (CNT !== 10'h2AA)  begin errs++; $display("FAIL loada_cnt got %h exp 2AA", CNT); end
    vecs++; if (GRAY !== 10'h3FF) begin errs++; $display("FAIL loada_gray got %h exp 3FF", GRAY); end
    MODE = 2'b10;
    next_tick();
    vecs++; if (CNT !== 10'h154) begin errs++; $display("FAIL shl1_cnt got %h exp 154", CNT); end
    vecs++; if (TC !== 1'b1)     begin errs++; $display("FAIL shl1_tc got %b exp 1", TC); end
    @(negedge CLK);
    vecs++; if (TC !== 1'b0)     begin errs++; $display("FAIL tc_width got %b exp 0", TC); end
    next_tick();
    vecs++; if (CNT !== 10'h2A8) begin errs++; $display("FAIL shl2_cnt got %h exp 2A8", CNT); end
    vecs++; if (TC !== 1'b0)     begin errs++; $display("FAIL shl2_tc got %b exp 0", TC); end
    next_tick();
    vecs++; if (CNT !== 10'h150) begin errs++; $display("FAIL shl3_cnt got %h exp 150", CNT); end
    vecs++; if (TC !== 1'b1)     begin errs++; $display("FAIL shl3_tc got %b exp 1", TC); end
  endtask

  task automatic test_rotate_sat();
    int tcs = 0;
    LOAD_B = 1'b1; @(negedge CLK); LOAD_B = 1'b0;
    MODE = 2'b11;
    repeat (10) begin next_tick(); if (TC === 1'b1) tcs++; end
    vecs++; if (CNT !== 10'h155) begin errs++; $display("FAIL rol_cnt got %h exp 155", CNT); end
    vecs++; if (tcs != 5)        begin errs++; $display("FAIL rol_tcs got %0d exp 5", tcs); end
    CMD_CLR = 1'b1; @(negedge CLK); CMD_CLR = 1'b0;
    vecs++; if (CNT !== 10'h000) begin errs++; $display("FAIL clr_cnt got %h exp 000", CNT); end
    MODE = 2'b01; SAT = 1'b1;
    next_tick();
    vecs++; if (CNT !== 10'h000 || TC !== 1'b1) begin errs++; $display("FAIL dn_sat got %h/%b exp 000/1", CNT, TC); end
    SAT = 1'b0;
    next_tick();
    vecs++; if (CNT !== 10'h3FF || TC !== 1'b1) begin errs++; $display("FAIL dn_wrap got %h/%b exp 3FF/1", CNT, TC); end
    MODE = 2'b00; SAT = 1'b1;
    next_tick();
    vecs++; if (CNT !== 10'h3FF || TC !== 1'b1) begin errs++; $display("FAIL up_sat got %h/%b exp 3FF/1", CNT, TC); end
    SAT = 1'b0;
    next_tick();
    vecs++; if (CNT !== 10'h000 || TC !== 1'b1) begin errs++; $display("FAIL up_wrap got %h/%b exp 000/1", CNT, TC); end
    next_tick();
    vecs++; if (CNT !== 10'h001 || TC !== 1'b0) begin errs++; $display("FAIL up_plain got %h/%b exp 001/0", CNT, TC); end
  endtask

  task automatic test_step();
    STEP_SEL = 1'b1; MODE = 2'b00;
    STEP = 1'b1; repeat (50) @(negedge CLK); STEP = 1'b0;
    repeat (3) begin @(negedge CLK); STEP = 1'b1; @(negedge CLK); STEP = 1'b0; end
    @(negedge CLK);
    vecs++; if (CNT !== 10'h005) begin errs++; $display("FAIL step_cnt got %h exp 005", CNT); end
    vecs++; if (ACT !== 2'(cyc / PER)) begin errs++; $display("FAIL step_act got %0d exp %0d", ACT, 2'(cyc / PER)); end
    next_tick();
    vecs++; if (CNT !== 10'h005) begin errs++; $display("FAIL step_tick_ignored got %h exp 005", CNT); end
    // STEP already high when manual mode is entered must not count.
    STEP_SEL = 1'b0; STEP = 1'b1;
    repeat (2) @(negedge CLK);
    STEP_SEL = 1'b1;
    repeat (5) @(negedge CLK);
    vecs++; if (CNT !== 10'h005) begin errs++; $display("FAIL step_prehigh got %h exp 005", CNT); end
    STEP = 1'b0; @(negedge CLK);
    STEP = 1'b1; @(negedge CLK); STEP = 1'b0;
    vecs++; if (CNT !== 10'h006) begin errs++; $display("FAIL step_fresh got %h exp 006", CNT); end
  endtask

  task automatic test_priority();
    @(negedge CLK);
    CMD_CLR = 1'b1; LOAD_A = 1'b1; STEP = 1'b1;
    @(negedge CLK);
    CMD_CLR = 1'b0; LOAD_A = 1'b0; STEP = 1'b0;
    vecs++; if (CNT !== 10'h000 || TC !== 1'b0) begin errs++; $display("FAIL clr_prio got %h/%b exp 000/0", CNT, TC); end
    LOAD_A = 1'b1; @(negedge CLK); LOAD_A = 1'b0;
    MODE = 2'b10;
    STEP = 1'b1; LOAD_B = 1'b1; @(negedge CLK); STEP = 1'b0; LOAD_B = 1'b0;
    vecs++; if (CNT !== 10'h155 || TC !== 1'b0) begin errs++; $display("FAIL loadb_prio got %h/%b exp 155/0", CNT, TC); end
    LOAD_A = 1'b1; LOAD_B = 1'b1; @(negedge CLK); LOAD_A = 1'b0; LOAD_B = 1'b0;
    vecs++; if (CNT !== 10'h2AA) begin errs++; $display("FAIL loadab_prio got %h exp 2AA", CNT); end
    STEP = 1'b1; @(negedge CLK); STEP = 1'b0;
    vecs++; if (CNT !== 10'h154 || TC !== 1'b1) begin errs++; $display("FAIL step_shl got %h/%b exp 154/1", CNT, TC); end
    STEP_SEL = 1'b0;
  endtask

  task automatic test_async_reset();
    LOAD_A = 1'b1; @(negedge CLK); LOAD_A = 1'b0;
    next_tick();
    vecs++; if (CNT !== 10'h154 || TC !== 1'b1) begin errs++; $display("FAIL pre_rst got %h/%b exp 154/1", CNT, TC); end
    #2 RST_N = 1'b0;
    #1;
    vecs++; if (CNT !== '0 || TC !== 1'b0 || ACT !== 2'd0 || GRAY !== '0)
      begin errs++; $display("FAIL async_rst got cnt=%h tc=%b act=%0d gray=%h exp 0", CNT, TC, ACT, GRAY); end
    @(negedge CLK);
    RST_N = 1'b1; MODE = 2'b00;
    repeat (15) @(negedge CLK);
    vecs++; if (CNT !== 10'h000) begin errs++; $display("FAIL post_rst_early got %h exp 000", CNT); end
    @(negedge CLK);
    vecs++; if (CNT !== 10'h001 || ACT !== 2'd1) begin errs++; $display("FAIL post_rst_tick got %h/%0d exp 001/1", CNT, ACT); end
  endtask

  initial begin
    test_reset();
    test_up_ticks();
    test_shift();
    test_rotate_sat();
    test_step();
    test_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
